// File: rtl/proc_pkg.sv
// Shared definitions for the step decoder: step codes, opcodes,
// ALU selects and the control word bundle.
package proc_pkg;

  localparam int IR_W   = 6;
  localparam int STEP_W = 6;
  localparam int DATA_W = 8;

  localparam logic [STEP_W-1:0] STEP_FETCH1 = 6'd1;
  localparam logic [STEP_W-1:0] STEP_FETCH2 = 6'd2;
  localparam logic [STEP_W-1:0] STEP_FETCH3 = 6'd3;
  localparam logic [STEP_W-1:0] STEP_EXT_LO = 6'd12;
  localparam logic [STEP_W-1:0] STEP_EXT_HI = 6'd35;
  localparam logic [STEP_W-1:0] STEP_ALU_LO = 6'd36;
  localparam logic [STEP_W-1:0] STEP_ALU_HI = 6'd51;
  localparam logic [STEP_W-1:0] STEP_NOP    = 6'd56;
  localparam logic [STEP_W-1:0] STEP_HALT   = 6'd57;

  localparam logic [IR_W-1:0] OP_FETCH = 6'd1;
  localparam logic [IR_W-1:0] OP_LOAD  = 6'd4;
  localparam logic [IR_W-1:0] OP_STORE = 6'd8;
  localparam logic [IR_W-1:0] OP_JUMP  = 6'd12;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;

  typedef struct packed {
    logic       ar_load;
    logic       pc_inc;
    logic       pc_load;
    logic       mem_read;
    logic       mem_write;
    logic       acc_load;
    logic       z_update;
    logic [3:0] alu_op;
  } strobe_t;

  typedef struct packed {
    strobe_t strb;
    logic    ir_load;
    logic    halt;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/step_ctrl_rom.sv
// Combinational map from step code to control word.
// Unlisted codes fall through to NOP.
module step_ctrl_rom
  import proc_pkg::*;
(
  input  logic [STEP_W-1:0] code_i,
  output ctrl_word_t        ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_NOP;
    case (code_i) inside
      6'd1, 6'd4, 6'd6, 6'd8, 6'd10, 6'd52:
        ctrl_o.strb.ar_load = 1'b1;
      6'd2, 6'd5, 6'd9: begin
        ctrl_o.strb.mem_read = 1'b1;
        ctrl_o.strb.pc_inc   = 1'b1;
      end
      STEP_FETCH3:
        ctrl_o.ir_load = 1'b1;
      6'd7: begin
        ctrl_o.strb.mem_read = 1'b1;
        ctrl_o.strb.acc_load = 1'b1;
      end
      6'd11:
        ctrl_o.strb.mem_write = 1'b1;
      [STEP_EXT_LO:STEP_EXT_HI]: begin
        if (code_i[0]) ctrl_o.strb.acc_load = 1'b1;
        else           ctrl_o.strb.mem_read = 1'b1;
      end
      [STEP_ALU_LO:STEP_ALU_HI]: begin
        ctrl_o.strb.acc_load = 1'b1;
        ctrl_o.strb.z_update = 1'b1;
        ctrl_o.strb.alu_op   = 4'(code_i - STEP_ALU_LO);
      end
      6'd53:
        ctrl_o.strb.pc_load = 1'b1;
      6'd54:
        ctrl_o.strb.pc_inc = 1'b1;
      6'd55, 6'd58, 6'd59:
        ctrl_o.strb.acc_load = 1'b1;
      STEP_HALT:
        ctrl_o.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/step_decoder.sv
// Registers the decoded step strobes and owns IR, Z flag and
// the sticky halt flag.
module step_decoder
  import proc_pkg::*;
#(
  parameter int INSTRUCTION_LEN = IR_W,
  parameter int SM_SIG_LEN      = STEP_W,
  parameter int DATA_LEN        = DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SM_SIG_LEN-1:0]      smInput,
  input  logic [INSTRUCTION_LEN-1:0] IRIn,
  input  logic [DATA_LEN-1:0]        mem_data,
  input  logic                       alu_zero,
  output logic [INSTRUCTION_LEN-1:0] IROut,
  output logic                       ar_load,
  output logic                       pc_inc,
  output logic                       pc_load,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       acc_load,
  output logic [3:0]                 alu_op,
  output logic                       z_out,
  output logic                       halted
);

  ctrl_word_t ctrl;

  step_ctrl_rom u_rom (
    .code_i (STEP_W'(smInput)),
    .ctrl_o (ctrl)
  );

  logic [INSTRUCTION_LEN-1:0] ir_q, ir_d;
  strobe_t                    strb_q, strb_d;
  logic                       z_q, z_d;
  logic                       halt_q, halt_d;
  logic                       run;
  logic                       unused_mem_hi;

  assign unused_mem_hi = ^mem_data[DATA_LEN-1:INSTRUCTION_LEN];
  assign run = start && !halt_q;

  always_comb begin
    ir_d   = ir_q;
    strb_d = '0;
    z_d    = z_q;
    halt_d = halt_q;
    if (run) begin
      strb_d = ctrl.strb;
      if (ctrl.ir_load)
        ir_d = mem_data[INSTRUCTION_LEN-1:0];
      else if (IRIn != '0)
        ir_d = IRIn;
      // Z samples the ALU during the cycle the z_update strobe is live
      if (strb_q.z_update)
        z_d = alu_zero;
      if (ctrl.halt)
        halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q   <= INSTRUCTION_LEN'(1);
      strb_q <= '0;
      z_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      strb_q <= strb_d;
      z_q    <= z_d;
      halt_q <= halt_d;
    end
  end

  assign IROut     = ir_q;
  assign ar_load   = strb_q.ar_load;
  assign pc_inc    = strb_q.pc_inc;
  assign pc_load   = strb_q.pc_load;
  assign mem_read  = strb_q.mem_read;
  assign mem_write = strb_q.mem_write;
  assign acc_load  = strb_q.acc_load;
  assign alu_op    = strb_q.alu_op;
  assign z_out     = z_q;
  assign halted    = halt_q;

endmodule

// File: tb/tb_step_decoder.sv
// Directed and random stimulus for step_decoder against a
// behavioural model of the decode table.
module tb_step_decoder;

  logic       clk = 1'b0;
  logic       reset, start, alu_zero;
  logic [5:0] smInput, IRIn, IROut;
  logic [7:0] mem_data;
  logic       ar_load, pc_inc, pc_load;
  logic       mem_read, mem_write, acc_load;
  logic [3:0] alu_op;
  logic       z_out, halted;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_ir;
  logic [5:0] exp_s;
  logic [3:0] exp_alu;
  logic       exp_z, exp_h, pend_z;

  step_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .smInput   (smInput),
    .IRIn      (IRIn),
    .mem_data  (mem_data),
    .alu_zero  (alu_zero),
    .IROut     (IROut),
    .ar_load   (ar_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .z_out     (z_out),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int  c;
    bit  ar, rd, inc, pcl, wr, acc, zu;
    int  alu;
    c = int'(smInput);
    if (reset) begin
      exp_ir = 6'd1; exp_s = '0; exp_alu = '0;
      exp_z = 0; exp_h = 0; pend_z = 0;
    end else if (!start || exp_h) begin
      exp_s = '0; exp_alu = '0; pend_z = 0;
    end else begin
      if (pend_z) exp_z = alu_zero;
      ar  = (c == 1 || c == 4 || c == 6 || c == 8 || c == 10 || c == 52);
      rd  = (c == 2 || c == 5 || c == 7 || c == 9)
            || (c >= 12 && c <= 35 && c % 2 == 0);
      inc = (c == 2 || c == 5 || c == 9 || c == 54);
      pcl = (c == 53);
      wr  = (c == 11);
      zu  = (c >= 36 && c <= 51);
      acc = (c == 7) || zu || (c >= 12 && c <= 35 && c % 2 == 1)
            || c == 55 || c == 58 || c == 59;
      alu = zu ? c - 36 : 0;
      if (c == 3) exp_ir = mem_data[5:0];
      else if (IRIn != 0) exp_ir = IRIn;
      if (c == 57) exp_h = 1;
      pend_z  = zu;
      exp_s   = {ar, inc, pcl, rd, wr, acc};
      exp_alu = 4'(alu);
    end
  endtask

  task automatic check_all(input string tag);
    checks++;
    assert ({ar_load, pc_inc, pc_load, mem_read, mem_write, acc_load} === exp_s)
    else begin
      errors++;
      $error("FAIL %s strobes: got %b exp %b", tag,
        {ar_load, pc_inc, pc_load, mem_read, mem_write, acc_load}, exp_s);
    end
    checks++;
    assert (alu_op === exp_alu) else begin
      errors++;
      $error("FAIL %s alu_op: got %0d exp %0d", tag, alu_op, exp_alu);
    end
    checks++;
    assert (IROut === exp_ir) else begin
      errors++;
      $error("FAIL %s IROut: got %0h exp %0h", tag, IROut, exp_ir);
    end
    checks++;
    assert (z_out === exp_z) else begin
      errors++;
      $error("FAIL %s z_out: got %b exp %b", tag, z_out, exp_z);
    end
    checks++;
    assert (halted === exp_h) else begin
      errors++;
      $error("FAIL %s halted: got %b exp %b", tag, halted, exp_h);
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic [5:0] code,
                     input logic [5:0] irin, input logic [7:0] md,
                     input logic az, input string tag);
    reset = r; start = st; smInput = code;
    IRIn = irin; mem_data = md; alu_zero = az;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic expect_const(input string tag, input logic [5:0] got,
                              input logic [5:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, want);
    end
  endtask

  initial begin
    exp_ir = 'x; exp_s = 'x; exp_alu = 'x;
    exp_z = 0; exp_h = 0; pend_z = 0;
    #2;
    cyc(1, 0, 0, 0, 0, 0, "reset");
    expect_const("reset_ir", IROut, 6'd1);

    cyc(0, 1, 1, 0, 8'h04, 0, "fetch1");
    expect_const("fetch1_ar", {5'd0, ar_load}, 6'd1);
    cyc(0, 1, 2, 0, 8'h04, 0, "fetch2");
    cyc(0, 1, 3, 0, 8'h04, 0, "fetch3");
    expect_const("fetch3_ir", IROut, 6'd4);

    cyc(0, 1, 36, 0, 0, 1, "alu36a");
    cyc(0, 1, 36, 0, 0, 1, "alu36b");
    expect_const("z_after", {5'd0, z_out}, 6'd1);
    cyc(0, 1, 56, 0, 0, 1, "nop");

    cyc(0, 1, 3, 1, 8'h2A, 0, "load_wins");
    expect_const("load_wins_ir", IROut, 6'h2A);

    cyc(0, 1, 57, 0, 0, 0, "halt");
    cyc(0, 1, 1, 0, 0, 0, "halt_1");
    cyc(0, 1, 2, 5, 0, 0, "halt_2");
    expect_const("halt_ir", IROut, 6'h2A);
    cyc(1, 1, 2, 0, 0, 0, "halt_rst");

    cyc(0, 0, 5, 0, 0, 0, "stop5");
    cyc(0, 1, 5, 0, 0, 0, "run5");
    expect_const("run5_rd", {4'd0, mem_read, pc_inc}, 6'd3);

    cyc(0, 1, 2, 0, 0, 0, "pre_rst");
    cyc(1, 1, 1, 9, 8'h11, 0, "mid_rst");

    for (int i = 0; i < 600; i++) begin
      logic r, st;
      logic [5:0] code, irin;
      r    = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 7) != 0);
      code = 6'($urandom_range(0, 63));
      if (code == 6'd57 && $urandom_range(0, 3) != 0) code = 6'd3;
      irin = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cyc(r, st, code, irin, 8'($urandom), 1'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
